// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: CPU, video and SRAM-controller side signals of the
// two-client SRAM arbiter; slave = arbiter view, master = client view.
interface sram_arbiter_if #(
    parameter int AW = 18,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_lb_n;
    logic          cpu_ub_n;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_rdata;
    logic          vid_ack;
    logic [AW-1:0] sr_addr;
    logic [DW-1:0] sr_dataw;
    logic          sr_lb_n;
    logic          sr_ub_n;
    logic          sr_rd;
    logic          sr_we_n;
    logic [DW-1:0] sr_datar;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lb_n, cpu_ub_n,
        output cpu_rdata, cpu_ack,
        input  vid_req, vid_addr,
        output vid_rdata, vid_ack,
        output sr_addr, sr_dataw, sr_lb_n, sr_ub_n, sr_rd, sr_we_n,
        input  sr_datar
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lb_n, cpu_ub_n,
        input  cpu_rdata, cpu_ack,
        output vid_req, vid_addr,
        input  vid_rdata, vid_ack,
        input  sr_addr, sr_dataw, sr_lb_n, sr_ub_n, sr_rd, sr_we_n,
        output sr_datar
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-client (CPU / video) front end for the SRAM controller.
// Grants fixed-length slots, drives the rd / we_n strobes, returns data + ack.
module sram_arbiter #(
    parameter int AW   = 18,
    parameter int DW   = 16,
    parameter int SLOT = 6
) (
    input logic           clk,
    input logic           reset_n,
    sram_arbiter_if.slave bus
);
    localparam int CW = $clog2(SLOT + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_OFF  = CW'(SLOT - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          last_vid;
    logic          last_vid_nx;
    logic          srv_vid;
    logic          srv_vid_nx;
    logic          srv_we;
    logic          srv_we_nx;

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_nx;
    logic [DW-1:0] dataw_q;
    logic [DW-1:0] dataw_nx;
    logic          lb_q;
    logic          lb_nx;
    logic          ub_q;
    logic          ub_nx;
    logic          rd_q;
    logic          rd_nx;
    logic          we_n_q;
    logic          we_n_nx;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] cpu_rdata_nx;
    logic [DW-1:0] vid_rdata_q;
    logic [DW-1:0] vid_rdata_nx;
    logic          cpu_ack_q;
    logic          cpu_ack_nx;
    logic          vid_ack_q;
    logic          vid_ack_nx;

    logic finish;
    logic can_grant;
    logic cpu_elig;
    logic vid_elig;
    logic grant_vid;
    logic grant_cpu;
    logic grant;

    // Slot end and arbitration; the client just served (or still acking)
    // is blanked so a registered client can drop req after its ack.
    assign finish    = (state == BUSY) && (cnt == CNT_LAST);
    assign can_grant = (state == IDLE) || finish;
    assign cpu_elig  = bus.cpu_req && !cpu_ack_q && !(finish && !srv_vid);
    assign vid_elig  = bus.vid_req && !vid_ack_q && !(finish && srv_vid);
    assign grant_vid = can_grant && vid_elig && (!cpu_elig || !last_vid);
    assign grant_cpu = can_grant && cpu_elig && !grant_vid;
    assign grant     = grant_vid || grant_cpu;

    // FSM state register: state, slot counter, served client, last winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            last_vid <= 1'b1;
            srv_vid  <= 1'b0;
            srv_we   <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            last_vid <= last_vid_nx;
            srv_vid  <= srv_vid_nx;
            srv_we   <= srv_we_nx;
        end
    end

    // Next-state logic: count the slot, retire it, start a new one.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        last_vid_nx = last_vid;
        srv_vid_nx  = srv_vid;
        srv_we_nx   = srv_we;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
            end
            BUSY: begin
                if (finish) begin
                    state_nx    = IDLE;
                    cnt_nx      = '0;
                    last_vid_nx = srv_vid;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        if (grant) begin
            state_nx   = BUSY;
            cnt_nx     = CNT_ONE;
            srv_vid_nx = grant_vid;
            srv_we_nx  = grant_cpu && bus.cpu_we;
        end
    end

    // Output logic: strobes, controller bus, read capture and acks.
    always_comb begin
        addr_nx      = addr_q;
        dataw_nx     = dataw_q;
        lb_nx        = lb_q;
        ub_nx        = ub_q;
        rd_nx        = rd_q;
        we_n_nx      = we_n_q;
        cpu_rdata_nx = cpu_rdata_q;
        vid_rdata_nx = vid_rdata_q;
        cpu_ack_nx   = 1'b0;
        vid_ack_nx   = 1'b0;
        if (state == BUSY && cnt == CNT_OFF) begin
            rd_nx   = 1'b0;
            we_n_nx = 1'b1;
        end
        if (finish) begin
            if (srv_vid) begin
                vid_ack_nx   = 1'b1;
                vid_rdata_nx = bus.sr_datar;
            end else begin
                cpu_ack_nx = 1'b1;
                if (!srv_we) begin
                    if (!lb_q) begin
                        cpu_rdata_nx[7:0] = bus.sr_datar[7:0];
                    end
                    if (!ub_q) begin
                        cpu_rdata_nx[DW-1:8] = bus.sr_datar[DW-1:8];
                    end
                end
            end
        end
        if (grant_vid) begin
            addr_nx  = bus.vid_addr;
            dataw_nx = '0;
            lb_nx    = 1'b0;
            ub_nx    = 1'b0;
            rd_nx    = 1'b1;
            we_n_nx  = 1'b1;
        end else if (grant_cpu) begin
            addr_nx  = bus.cpu_addr;
            dataw_nx = bus.cpu_wdata;
            lb_nx    = bus.cpu_lb_n;
            ub_nx    = bus.cpu_ub_n;
            rd_nx    = !bus.cpu_we;
            we_n_nx  = !bus.cpu_we;
        end
    end

    // Output registers; reset drops the strobes and abandons any slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            dataw_q     <= '0;
            lb_q        <= 1'b1;
            ub_q        <= 1'b1;
            rd_q        <= 1'b0;
            we_n_q      <= 1'b1;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
        end else begin
            addr_q      <= addr_nx;
            dataw_q     <= dataw_nx;
            lb_q        <= lb_nx;
            ub_q        <= ub_nx;
            rd_q        <= rd_nx;
            we_n_q      <= we_n_nx;
            cpu_rdata_q <= cpu_rdata_nx;
            vid_rdata_q <= vid_rdata_nx;
            cpu_ack_q   <= cpu_ack_nx;
            vid_ack_q   <= vid_ack_nx;
        end
    end

    assign bus.sr_addr   = addr_q;
    assign bus.sr_dataw  = dataw_q;
    assign bus.sr_lb_n   = lb_q;
    assign bus.sr_ub_n   = ub_q;
    assign bus.sr_rd     = rd_q;
    assign bus.sr_we_n   = we_n_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.vid_rdata = vid_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.vid_ack   = vid_ack_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vector table, corner sequences and randomized
// two-client traffic against an SRAM model and a client-level memory model.
`timescale 1ns/1ps
module tb_sram_arbiter;
    localparam int AW = 18;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    sram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    sram_arbiter #(.AW(AW), .DW(DW), .SLOT(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old,
                                          input logic [15:0] nw,
                                          input logic lb_n,
                                          input logic ub_n);
        logic [15:0] r;
        r = old;
        if (!lb_n) r[7:0] = nw[7:0];
        if (!ub_n) r[15:8] = nw[15:8];
        return r;
    endfunction

    // SRAM controller model: edge-triggered rd / we_n, byte-lane writes.
    bit [15:0]   mem [0:(1<<AW)-1];
    logic        pre_en;
    logic [17:0] pre_addr;
    logic [15:0] pre_val;
    logic        prev_rd;
    logic        prev_we_n;

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_addr] <= pre_val;
        else if (reset_n && !bus.sr_we_n && prev_we_n)
            mem[bus.sr_addr] <= merge(mem[bus.sr_addr], bus.sr_dataw,
                                      bus.sr_lb_n, bus.sr_ub_n);
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_rd      <= 1'b0;
            prev_we_n    <= 1'b1;
            bus.sr_datar <= '0;
        end else begin
            prev_rd   <= bus.sr_rd;
            prev_we_n <= bus.sr_we_n;
            if (bus.sr_rd && !prev_rd)
                bus.sr_datar <= mem[bus.sr_addr];
        end
    end

    // Exclusivity of strobes and acks, checked every cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("strobe_excl", 32'(bus.sr_rd && !bus.sr_we_n), 32'(0));
            chk("ack_excl", 32'(bus.cpu_ack && bus.vid_ack), 32'(0));
        end
    end

    bit [15:0] sh [bit [17:0]];
    logic [15:0] cpu_exp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [17:0] a, input logic [15:0] v);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_val  = v;
        tick();
        pre_en = 1'b0;
        sh[a]  = v;
    endtask

    task automatic set_cpu(input bit we, input logic [17:0] a,
                           input logic [15:0] wd, input bit lb_n,
                           input bit ub_n);
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        bus.cpu_lb_n  = lb_n;
        bus.cpu_ub_n  = ub_n;
        bus.cpu_req   = 1'b1;
    endtask

    task automatic wait_ack(input bit vid, input string name);
        int n;
        n = 0;
        while (!(vid ? bus.vid_ack : bus.cpu_ack) && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(vid ? bus.vid_ack : bus.cpu_ack), 32'(1));
    endtask

    typedef struct {
        bit          we;
        logic [17:0] addr;
        logic [15:0] wdata;
        bit          lb_n;
        bit          ub_n;
        logic [15:0] exp_rdata;
        logic [15:0] exp_mem;
    } vec_t;

    vec_t vt [10];

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int  acks;
        int  rds;
        int  t_q[$];
        bit  w_q[$];

        vt[0] = '{1'b0, 18'h00123, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'hBEEF};
        vt[1] = '{1'b1, 18'h3FFFF, 16'hA55A, 1'b0, 1'b1, 16'hBEEF, 16'h115A};
        vt[2] = '{1'b0, 18'h3FFFF, 16'h0F0F, 1'b0, 1'b0, 16'h115A, 16'h115A};
        vt[3] = '{1'b0, 18'h00200, 16'h0000, 1'b0, 1'b0, 16'h1200, 16'h1200};
        vt[4] = '{1'b0, 18'h00201, 16'h0000, 1'b0, 1'b1, 16'h1234, 16'hFF34};
        vt[5] = '{1'b0, 18'h00123, 16'h0000, 1'b1, 1'b0, 16'hBE34, 16'hBEEF};
        vt[6] = '{1'b1, 18'h00000, 16'hC3C3, 1'b1, 1'b0, 16'hBE34, 16'hC381};
        vt[7] = '{1'b0, 18'h00000, 16'h0000, 1'b0, 1'b0, 16'hC381, 16'hC381};
        vt[8] = '{1'b1, 18'h00010, 16'h1234, 1'b1, 1'b1, 16'hC381, 16'hABCD};
        vt[9] = '{1'b0, 18'h00010, 16'h5555, 1'b1, 1'b1, 16'hC381, 16'hABCD};

        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_lb_n  = 1'b1;
        bus.cpu_ub_n  = 1'b1;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
        pre_en        = 1'b0;
        pre_addr      = '0;
        pre_val       = '0;

        #2 reset_n = 1'b0;
        repeat (2) tick();
        chk("rst_sr_rd", 32'(bus.sr_rd), 32'(0));
        chk("rst_sr_we_n", 32'(bus.sr_we_n), 32'(1));
        chk("rst_lanes", 32'({bus.sr_lb_n, bus.sr_ub_n}), 32'(3));
        chk("rst_sr_addr", 32'(bus.sr_addr), 32'(0));
        chk("rst_sr_dataw", 32'(bus.sr_dataw), 32'(0));
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'(0));
        chk("rst_vid_rdata", 32'(bus.vid_rdata), 32'(0));
        chk("rst_acks", 32'({bus.cpu_ack, bus.vid_ack}), 32'(0));

        preload(18'h00123, 16'hBEEF);
        preload(18'h3FFFF, 16'h1111);
        preload(18'h00200, 16'h1200);
        preload(18'h00201, 16'hFF34);
        preload(18'h00000, 16'h7E81);
        preload(18'h00010, 16'hABCD);
        #3 reset_n = 1'b1;
        tick();

        // Directed CPU accesses from the vector table.
        for (int i = 0; i < 10; i++) begin
            set_cpu(vt[i].we, vt[i].addr, vt[i].wdata,
                    vt[i].lb_n, vt[i].ub_n);
            tick();
            chk($sformatf("v%0d_e0_strobe", i),
                32'({bus.sr_rd, bus.sr_we_n}),
                32'(vt[i].we ? 2'b00 : 2'b11));
            chk($sformatf("v%0d_e0_addr", i), 32'(bus.sr_addr),
                32'(vt[i].addr));
            chk($sformatf("v%0d_e0_lanes", i),
                32'({bus.sr_lb_n, bus.sr_ub_n}),
                32'({vt[i].lb_n, vt[i].ub_n}));
            chk($sformatf("v%0d_e0_dataw", i), 32'(bus.sr_dataw),
                32'(vt[i].wdata));
            repeat (4) tick();
            chk($sformatf("v%0d_e4_strobe", i),
                32'({bus.sr_rd, bus.sr_we_n}),
                32'(vt[i].we ? 2'b00 : 2'b11));
            tick();
            chk($sformatf("v%0d_e5_strobe", i),
                32'({bus.sr_rd, bus.sr_we_n}), 32'(2'b01));
            chk($sformatf("v%0d_e5_ack", i), 32'(bus.cpu_ack), 32'(0));
            tick();
            chk($sformatf("v%0d_e6_ack", i), 32'(bus.cpu_ack), 32'(1));
            chk($sformatf("v%0d_rdata", i), 32'(bus.cpu_rdata),
                32'(vt[i].exp_rdata));
            chk($sformatf("v%0d_mem", i), 32'(mem[vt[i].addr]),
                32'(vt[i].exp_mem));
            bus.cpu_req = 1'b0;
            tick();
            chk($sformatf("v%0d_e7_ack", i), 32'(bus.cpu_ack), 32'(0));
        end

        // Video read: lanes forced on, write data forced to zero.
        bus.vid_addr = 18'h00123;
        bus.vid_req  = 1'b1;
        tick();
        chk("vid_e0_rd", 32'({bus.sr_rd, bus.sr_we_n}), 32'(2'b11));
        chk("vid_e0_lanes", 32'({bus.sr_lb_n, bus.sr_ub_n}), 32'(0));
        chk("vid_e0_dataw", 32'(bus.sr_dataw), 32'(0));
        repeat (6) tick();
        chk("vid_e6_ack", 32'(bus.vid_ack), 32'(1));
        chk("vid_rdata", 32'(bus.vid_rdata), 32'(16'hBEEF));
        bus.vid_req = 1'b0;
        tick();

        // Video served last: CPU wins a tie, video follows at E6.
        set_cpu(1'b0, 18'h00200, 16'h0000, 1'b0, 1'b0);
        bus.vid_addr = 18'h00201;
        bus.vid_req  = 1'b1;
        tick();
        chk("prio_cpu_addr", 32'(bus.sr_addr), 32'(18'h00200));
        wait_ack(1'b0, "prio_cpu_ack");
        chk("prio_cpu_rdata", 32'(bus.cpu_rdata), 32'(16'h1200));
        chk("b2b_vid_addr", 32'(bus.sr_addr), 32'(18'h00201));
        chk("b2b_vid_rd", 32'(bus.sr_rd), 32'(1));
        tick();
        bus.cpu_req = 1'b0;
        wait_ack(1'b1, "b2b_vid_ack");
        chk("b2b_vid_rdata", 32'(bus.vid_rdata), 32'(16'hFF34));
        bus.vid_req = 1'b0;
        acks = 0;
        rds  = 0;
        repeat (12) begin
            tick();
            acks += int'(bus.cpu_ack) + int'(bus.vid_ack);
            rds  += int'(bus.sr_rd);
        end
        chk("hold_other_no_regrant", 32'(acks + rds), 32'(0));

        // Lone CPU holding req one cycle past its ack: arbiter goes idle.
        set_cpu(1'b0, 18'h00123, 16'h0000, 1'b0, 1'b0);
        wait_ack(1'b0, "hold_cpu_ack");
        chk("hold_cpu_rdata", 32'(bus.cpu_rdata), 32'(16'hBEEF));
        tick();
        bus.cpu_req = 1'b0;
        acks = 0;
        rds  = 0;
        repeat (12) begin
            tick();
            acks += int'(bus.cpu_ack) + int'(bus.vid_ack);
            rds  += int'(bus.sr_rd);
        end
        chk("hold_idle_no_regrant", 32'(acks + rds), 32'(0));

        // CPU served last: video wins a tie.
        set_cpu(1'b0, 18'h00201, 16'h0000, 1'b0, 1'b0);
        bus.vid_addr = 18'h00123;
        bus.vid_req  = 1'b1;
        tick();
        chk("prio_vid_addr", 32'(bus.sr_addr), 32'(18'h00123));
        wait_ack(1'b1, "prio_vid_ack");
        bus.vid_req = 1'b0;
        chk("prio_cpu_next_addr", 32'(bus.sr_addr), 32'(18'h00201));
        wait_ack(1'b0, "prio_cpu_next_ack");
        chk("prio_cpu_next_rdata", 32'(bus.cpu_rdata), 32'(16'hFF34));
        bus.cpu_req = 1'b0;
        repeat (3) tick();

        // Reset at E3 of a write abandons the slot.
        set_cpu(1'b1, 18'h03000, 16'h1357, 1'b0, 1'b0);
        repeat (4) tick();
        chk("e3_we_n_low", 32'(bus.sr_we_n), 32'(0));
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_we_n", 32'(bus.sr_we_n), 32'(1));
        chk("mid_rst_rd", 32'(bus.sr_rd), 32'(0));
        chk("mid_rst_addr", 32'(bus.sr_addr), 32'(0));
        chk("mid_rst_ack", 32'(bus.cpu_ack), 32'(0));

        // Both requesting from reset release: alternating back-to-back.
        set_cpu(1'b0, 18'h00200, 16'h0000, 1'b0, 1'b0);
        bus.vid_addr = 18'h00123;
        bus.vid_req  = 1'b1;
        @(posedge clk);
        #3 reset_n = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (bus.cpu_ack) begin
                t_q.push_back(c);
                w_q.push_back(1'b0);
                chk("alt_cpu_rdata", 32'(bus.cpu_rdata), 32'(16'h1200));
            end else if (bus.vid_ack) begin
                t_q.push_back(c);
                w_q.push_back(1'b1);
                chk("alt_vid_rdata", 32'(bus.vid_rdata), 32'(16'hBEEF));
            end
        end
        chk("alt_ack_count", 32'(t_q.size()), 32'(4));
        if (t_q.size() > 0)
            chk("alt_first_ack", 32'(t_q[0]), 32'(7));
        for (int i = 1; i < t_q.size(); i++) begin
            chk("alt_gap", 32'(t_q[i] - t_q[i-1]), 32'(6));
            chk("alt_switch", 32'(w_q[i] ^ w_q[i-1]), 32'(1));
        end
        bus.cpu_req = 1'b0;
        bus.vid_req = 1'b0;
        repeat (16) tick();

        // Randomized traffic against a client-level memory model.
        #2 reset_n = 1'b0;
        tick();
        for (int a = 0; a < 16; a++) begin
            preload(18'(a), 16'($urandom));
            preload(18'(32'h100 + a), 16'($urandom));
        end
        cpu_exp = 16'h0000;
        #3 reset_n = 1'b1;
        tick();
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    bit          we;
                    bit          lb_n;
                    bit          ub_n;
                    logic [17:0] a;
                    logic [15:0] wd;
                    int          n;
                    repeat ($urandom_range(1, 4)) tick();
                    we   = 1'($urandom_range(0, 1));
                    lb_n = 1'($urandom_range(0, 1));
                    ub_n = 1'($urandom_range(0, 1));
                    a    = 18'($urandom_range(0, 15));
                    wd   = 16'($urandom);
                    set_cpu(we, a, wd, lb_n, ub_n);
                    n = 0;
                    while (!bus.cpu_ack && n < 20) begin
                        tick();
                        n++;
                    end
                    chk("rnd_cpu_latency", 32'(bus.cpu_ack && n <= 13),
                        32'(1));
                    if (we)
                        sh[a] = merge(sh[a], wd, lb_n, ub_n);
                    else
                        cpu_exp = merge(cpu_exp, sh[a], lb_n, ub_n);
                    chk("rnd_cpu_rdata", 32'(bus.cpu_rdata), 32'(cpu_exp));
                    if ($urandom_range(0, 1) == 1) tick();
                    bus.cpu_req = 1'b0;
                end
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    logic [17:0] a;
                    int          n;
                    repeat ($urandom_range(1, 4)) tick();
                    a = 18'(32'h100 + $urandom_range(0, 15));
                    bus.vid_addr = a;
                    bus.vid_req  = 1'b1;
                    n = 0;
                    while (!bus.vid_ack && n < 20) begin
                        tick();
                        n++;
                    end
                    chk("rnd_vid_latency", 32'(bus.vid_ack && n <= 13),
                        32'(1));
                    chk("rnd_vid_rdata", 32'(bus.vid_rdata), 32'(sh[a]));
                    if ($urandom_range(0, 1) == 1) tick();
                    bus.vid_req = 1'b0;
                end
            end
        join
        repeat (3) tick();
        for (int a = 0; a < 16; a++)
            chk("rnd_mem_final", 32'(mem[18'(a)]), 32'(sh[18'(a)]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
